qspi_xip_reader: RTL and testbench
==================================

QSPI_XIP_READER -- requirements
Module: qspi_xip_reader

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 128: bits fetched per transaction; legal values are 32, 64, 128 and 256; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter DUMMY_CYCLES, default 4: sck cycles in the dummy phase; legal range 2..8.
REQ-003 SHALL have parameter CLK_DIV, default 1: sck half-period in clk cycles; legal range 1..4.
REQ-004 SHALL have parameter CONT_MODE, default 1: 1 enables continuous-read (command skip).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port addr, input, 24: byte address, sampled when a request is accepted.
REQ-008 SHALL have port rd, input, 1: request strobe; accepted on a clk edge where rd=1 and busy=0.
REQ-009 SHALL have port busy, output, 1: transaction in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking that line is updated.
REQ-011 SHALL have port line, output, LINE_SIZE: last fetched line.
REQ-012 SHALL have port sck, output, 1: flash clock.
REQ-013 SHALL have port ce_n, output, 1: flash chip enable, active-low.
REQ-014 SHALL have port din, input, 4: quad data from flash.
REQ-015 SHALL have port dout, output, 4: quad data to flash.
REQ-016 SHALL have port douten, output, 1: 1 = the controller drives dout onto the pads.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, ADDR, MODE, DUMMY, DATA and DONE.
REQ-018 On acceptance at edge T0: latch addr; set busy=1 and ce_n=0; enter CMD, or ADDR when the xip flag is set.
REQ-019 While ce_n=0, sck SHALL toggle every CLK_DIV clk cycles, starting low; sck SHALL be 0 whenever ce_n=1.
REQ-020 CMD: 8 sck cycles; dout[0] carries 0xEB MSB-first; dout[3:1]=0; douten=1.
REQ-021 ADDR: 6 sck cycles; dout carries addr[23:20] first through addr[3:0] last; douten=1.
REQ-022 MODE: 2 sck cycles; dout carries 0xA5 when CONT_MODE=1, else 0xFF; high nibble first; douten=1.
REQ-023 DUMMY: DUMMY_CYCLES sck cycles; douten=0.
REQ-024 DATA: LINE_SIZE/4 sck cycles; douten=0.
REQ-025 dout SHALL change only on clk edges where sck goes 1->0, or at T0.
REQ-026 din SHALL be sampled on each clk edge where sck goes 1->0 during DATA.
REQ-027 Nibble ordering: the first nibble is the high nibble of byte 0; byte k maps to line[8k+7:8k].
REQ-028 Data SHALL be shifted into an internal register; line SHALL update only at the edge that asserts done and hold until the next done.
REQ-029 At the edge after the last DATA sample: done=1 for one cycle; ce_n=1; sck=0; state DONE.
REQ-030 busy SHALL stay 1 during the DONE cycle and fall on the following edge, guaranteeing ce_n high for at least 2 clk.
REQ-031 Define N = 8·(xip flag clear) + 6 + 2 + DUMMY_CYCLES + LINE_SIZE/4.
REQ-032 done SHALL assert exactly 2·CLK_DIV·N + 1 clk cycles after T0.
REQ-033 The xip flag SHALL set at done of a transaction sent with mode 0xA5; it is never set when CONT_MODE=0.
REQ-034 rd while busy=1, including the DONE cycle, SHALL be ignored and not queued.
REQ-035 addr changes while busy SHALL have no effect.

Reset
REQ-036 On rst_n=0 at any time, including mid-transaction: state IDLE; ce_n=1; sck=0; busy=0; done=0; douten=1; dout=0; xip flag cleared; line=0.
REQ-037 After reset release, the first transaction SHALL always include CMD.

Verification
REQ-038 Defaults, rd with addr=0x001230, flash model returning bytes 0x00..0x0F -> 0xEB on dout[0], then nibbles 0,0,1,2,3,0, then A,5; done at T0+105; line=0x0F0E..0100.
REQ-039 Second rd after REQ-038 with addr=0x000040 -> no CMD phase; first ce_n-low dout nibble=0; done at T0+89.
REQ-040 CONT_MODE=0, CLK_DIV=2, LINE_SIZE=32, DUMMY_CYCLES=6, two back-to-back rd -> both include CMD; mode nibbles F,F; done each at T0+4·30+1=121; ce_n high ≥2 clk between transactions.
REQ-041 rd pulsed while busy and during the done cycle -> ignored; exactly one done; busy falls one cycle after done.
REQ-042 rst_n asserted mid-DATA -> immediate ce_n=1, sck=0, busy=0, line=0; the next rd includes CMD.

Source files
------------

// File: rtl/qspi_xip_reader.sv
// Quad-SPI execute-in-place line reader: issues 0xEB fast-read transactions and
// returns one LINE_SIZE-bit line per request, skipping the command once continuous-read is armed.
module qspi_xip_reader #(
    parameter int LINE_SIZE    = 128,
    parameter int DUMMY_CYCLES = 4,
    parameter int CLK_DIV      = 1,
    parameter int CONT_MODE    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [23:0]          addr,
    input  logic                 rd,
    output logic                 busy,
    output logic                 done,
    output logic [LINE_SIZE-1:0] line,
    output logic                 sck,
    output logic                 ce_n,
    input  logic [3:0]           din,
    output logic [3:0]           dout,
    output logic                 douten
);

    if (!(LINE_SIZE == 32 || LINE_SIZE == 64 || LINE_SIZE == 128 || LINE_SIZE == 256)) begin : g_bad_line
        $error("qspi_xip_reader: LINE_SIZE must be 32, 64, 128 or 256");
    end
    if (DUMMY_CYCLES < 2 || DUMMY_CYCLES > 8) begin : g_bad_dummy
        $error("qspi_xip_reader: DUMMY_CYCLES must be in 2..8");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
        $error("qspi_xip_reader: CLK_DIV must be in 1..4");
    end

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE} state_t;

    localparam logic [7:0] CMD_BYTE  = 8'hEB;
    localparam logic [7:0] MODE_BYTE = (CONT_MODE == 1) ? 8'hA5 : 8'hFF;
    localparam logic [1:0] DIV_LAST  = 2'(CLK_DIV - 1);

    state_t               state;
    logic [1:0]           div_cnt;
    logic [7:0]           cnt;
    logic [7:0]           cnt_nx;
    logic                 data_end;
    logic                 xip;
    logic [23:0]          addr_q;
    logic [LINE_SIZE-1:0] shreg;

    assign cnt_nx = cnt + 8'd1;

    function automatic logic [7:0] phase_len(state_t s);
        case (s)
            CMD:     return 8'd8;
            ADDR:    return 8'd6;
            MODE:    return 8'd2;
            DUMMY:   return 8'(DUMMY_CYCLES);
            DATA:    return 8'(LINE_SIZE / 4);
            default: return 8'd1;
        endcase
    endfunction

    function automatic state_t next_phase(state_t s);
        case (s)
            CMD:     return ADDR;
            ADDR:    return MODE;
            MODE:    return DUMMY;
            default: return DATA;
        endcase
    endfunction

    // Nibble presented on the pads during sck cycle idx of phase s.
    function automatic logic [3:0] nibble(state_t s, logic [2:0] idx, logic [23:0] a);
        logic [23:0] sh;
        sh = a << {idx, 2'b00};
        case (s)
            CMD:     return {3'b000, CMD_BYTE[3'd7 - idx]};
            ADDR:    return sh[23:20];
            MODE:    return idx[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
            default: return 4'h0;
        endcase
    endfunction

    // The first received byte sits at the top of the shift register but belongs in line[7:0].
    function automatic logic [LINE_SIZE-1:0] byte_order(logic [LINE_SIZE-1:0] s);
        logic [LINE_SIZE-1:0] r;
        r = '0;
        for (int k = 0; k < LINE_SIZE / 8; k++) begin
            r[8*k +: 8] = s[LINE_SIZE-1-8*k -: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ce_n     <= 1'b1;
            sck      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            douten   <= 1'b1;
            dout     <= 4'h0;
            xip      <= 1'b0;
            line     <= '0;
            div_cnt  <= 2'd0;
            cnt      <= 8'd0;
            data_end <= 1'b0;
            addr_q   <= 24'h0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd) begin
                        addr_q   <= addr;
                        busy     <= 1'b1;
                        ce_n     <= 1'b0;
                        sck      <= 1'b0;
                        douten   <= 1'b1;
                        div_cnt  <= 2'd0;
                        cnt      <= 8'd0;
                        data_end <= 1'b0;
                        if (xip) begin
                            state <= ADDR;
                            dout  <= nibble(ADDR, 3'd0, addr);
                        end else begin
                            state <= CMD;
                            dout  <= nibble(CMD, 3'd0, addr);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (data_end) begin
                        done   <= 1'b1;
                        line   <= byte_order(shreg);
                        ce_n   <= 1'b1;
                        sck    <= 1'b0;
                        douten <= 1'b1;
                        xip    <= (CONT_MODE == 1);
                        state  <= DONE;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= 2'd0;
                        sck     <= ~sck;
                        // Falling sck edge: sample data, advance the bit counter and update the pads.
                        if (sck) begin
                            if (state == DATA) begin
                                shreg <= {shreg[LINE_SIZE-5:0], din};
                            end
                            if (cnt == phase_len(state) - 8'd1) begin
                                cnt <= 8'd0;
                                if (state == DATA) begin
                                    data_end <= 1'b1;
                                end else begin
                                    state  <= next_phase(state);
                                    dout   <= nibble(next_phase(state), 3'd0, addr_q);
                                    douten <= (state == CMD) || (state == ADDR);
                                end
                            end else begin
                                cnt  <= cnt_nx;
                                dout <= nibble(state, cnt_nx[2:0], addr_q);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_xip_reader.sv
// Bench for qspi_xip_reader: two configurations, each with a behavioural quad flash that
// decodes the serial stream on its own, checked against a transaction-level protocol model.
`timescale 1ns/1ps
module tb_qspi_xip_reader;

    localparam int LS0 = 128, DIV0 = 1, DM0 = 4, CM0 = 1;
    localparam int LS1 = 32,  DIV1 = 2, DM1 = 6, CM1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_v   [2];
    logic        rd_v    [2];
    logic [23:0] addr_v  [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        sck_v   [2];
    logic        ce_v    [2];
    logic        douten_v[2];
    logic [3:0]  dout_v  [2];
    logic [255:0] line_v [2];
    int          rises_v [2];
    int          viol_v  [2];
    int          gap_v   [2];
    int          dcnt_v  [2];
    logic [7:0]  mem [2][256];
    bit          mx  [2];

    int passed = 0;
    int total  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int LS  = (g == 0) ? LS0  : LS1;
        localparam int DIV = (g == 0) ? DIV0 : DIV1;
        localparam int DM  = (g == 0) ? DM0  : DM1;
        localparam int CM  = (g == 0) ? CM0  : CM1;

        logic          busy, done, sck, ce_n, douten;
        logic [3:0]    dout;
        logic [LS-1:0] line;
        logic [3:0]    din = 4'h0;

        qspi_xip_reader #(.LINE_SIZE(LS), .DUMMY_CYCLES(DM), .CLK_DIV(DIV), .CONT_MODE(CM)) u_dut (
            .clk(clk), .rst_n(rst_v[g]), .addr(addr_v[g]), .rd(rd_v[g]),
            .busy(busy), .done(done), .line(line), .sck(sck), .ce_n(ce_n),
            .din(din), .dout(dout), .douten(douten)
        );

        assign busy_v[g]   = busy;
        assign done_v[g]   = done;
        assign sck_v[g]    = sck;
        assign ce_v[g]     = ce_n;
        assign douten_v[g] = douten;
        assign dout_v[g]   = dout;
        assign line_v[g]   = 256'(line);

        // Flash: records what it sees on each rising sck, decodes address/mode, serves data.
        int          rises = 0;
        logic [23:0] fa = 24'h0;
        logic [7:0]  fm = 8'h0;
        bit          fxip = 1'b0;
        logic        pce = 1'b1;
        logic [4:0]  strm [256];
        always @(posedge sck or posedge ce_n or negedge ce_n) begin
            int pre, j;
            logic [7:0] ix, b;
            pre = fxip ? 0 : 8;
            if (ce_n !== pce) begin
                if (ce_n === 1'b0) begin
                    rises = 0; fa = 24'h0; fm = 8'h0;
                end else begin
                    fxip = (fm == 8'hA5) && (rises >= pre + 8 + DM + LS / 4);
                end
                pce = ce_n;
            end else if (ce_n === 1'b0) begin
                if (rises < 256) strm[rises] = {douten, dout};
                if (rises >= pre && rises < pre + 6) fa = {fa[19:0], dout};
                else if (rises >= pre + 6 && rises < pre + 8) fm = {fm[3:0], dout};
                else if (rises >= pre + 8 + DM) begin
                    j   = rises - (pre + 8 + DM);
                    ix  = fa[7:0] + 8'(j / 2);
                    b   = mem[g][ix];
                    din = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
                rises++;
            end
        end

        int         hi = 0, viol = 0, gap = 1000, dcnt = 0;
        bit         seen = 1'b0;
        logic       psck = 1'b0, pce2 = 1'b1;
        logic [3:0] pdout = 4'h0;
        always @(negedge clk) begin
            if (ce_n) hi++;
            else begin
                if (seen && hi > 0 && hi < gap) gap = hi;
                hi = 0; seen = 1'b1;
            end
            if (ce_n && sck) viol++;
            if (rst_v[g] && seen && dout !== pdout && !(psck && !sck) && !(pce2 && !ce_n)) viol++;
            if (done) dcnt++;
            pdout = dout; psck = sck; pce2 = ce_n;
        end

        assign rises_v[g] = rises;
        assign viol_v[g]  = viol;
        assign gap_v[g]   = gap;
        assign dcnt_v[g]  = dcnt;
    end

    function automatic logic [4:0] strm_at(int u, int i);
        if (u == 0) return g_u[0].strm[i];
        return g_u[1].strm[i];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic txn(input int u, input logic [23:0] a, input bit poke, input string tag);
        int ls, div, dm, cm, pre, n, t0, d0, bad;
        bit got;
        logic [255:0] exp;
        logic [7:0]  cmdb, modeb;
        logic [23:0] sh;
        logic [4:0]  e, s;
        ls  = (u == 0) ? LS0 : LS1;   div = (u == 0) ? DIV0 : DIV1;
        dm  = (u == 0) ? DM0 : DM1;   cm  = (u == 0) ? CM0 : CM1;
        pre = mx[u] ? 0 : 8;
        n   = pre + 8 + dm + ls / 4;
        cmdb = 8'hEB;
        modeb = (cm == 1) ? 8'hA5 : 8'hFF;
        d0 = dcnt_v[u];
        @(negedge clk); addr_v[u] = a; rd_v[u] = 1'b1;
        @(negedge clk); t0 = cyc; rd_v[u] = poke; addr_v[u] = 24'($urandom);
        chk({tag, "/busy_at_start"}, busy_v[u], 1);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (done_v[u]) got = 1'b1;
            else begin
                @(negedge clk);
                if (poke) begin rd_v[u] = 1'($urandom_range(0, 1)); addr_v[u] = 24'($urandom); end
            end
        end
        chk({tag, "/done_seen"}, got, 1);
        if (!got) return;
        chk({tag, "/latency"}, 256'(cyc - t0), 256'(2 * div * n + 1));
        chk({tag, "/busy_in_done"}, busy_v[u], 1);
        chk({tag, "/ce_sck_in_done"}, {ce_v[u], sck_v[u]}, 2'b10);
        if (poke) rd_v[u] = 1'b1;
        exp = '0;
        for (int k = 0; k < ls / 8; k++) exp[8*k +: 8] = mem[u][8'(a[7:0] + 8'(k))];
        chk({tag, "/line"}, line_v[u], exp);
        chk({tag, "/sck_cycles"}, 256'(rises_v[u]), 256'(n));
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i < pre) e = {1'b1, 3'b000, cmdb[7 - i]};
            else if (i < pre + 6) begin sh = a << (4 * (i - pre)); e = {1'b1, sh[23:20]}; end
            else if (i < pre + 8) e = {1'b1, (i == pre + 6) ? modeb[7:4] : modeb[3:0]};
            else e = 5'b0;
            s = strm_at(u, i);
            if (i < pre + 8 ? (s !== e) : (s[4] !== 1'b0)) bad++;
        end
        chk({tag, "/pad_stream"}, 256'(bad), 0);
        mx[u] = (cm == 1);
        @(negedge clk); rd_v[u] = 1'b0;
        chk({tag, "/busy_after_done"}, busy_v[u], 0);
        chk({tag, "/done_pulse_count"}, 256'(dcnt_v[u] - d0), 1);
    endtask

    initial begin
        bit got;
        int pre;
        logic [23:0] a;
        for (int u = 0; u < 2; u++) begin
            rst_v[u] = 1'b0; rd_v[u] = 1'b0; addr_v[u] = 24'h0; mx[u] = 1'b0;
            for (int i = 0; i < 256; i++) mem[u][i] = 8'($urandom);
        end
        for (int k = 0; k < 16; k++) mem[0][8'h30 + k] = 8'(k);
        repeat (3) @(negedge clk);
        chk("reset/ce_n", ce_v[0], 1);
        chk("reset/sck", sck_v[0], 0);
        chk("reset/busy", busy_v[0], 0);
        chk("reset/done", done_v[0], 0);
        chk("reset/douten_dout", {douten_v[0], dout_v[0]}, 5'h10);
        chk("reset/line", line_v[0], 0);
        chk("reset/b_ce_busy", {ce_v[1], busy_v[1]}, 2'b10);
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;

        txn(0, 24'h001230, 1'b0, "first_read");
        chk("first_read/literal_line", line_v[0], 256'h0F0E0D0C0B0A09080706050403020100);
        txn(0, 24'h000040, 1'b0, "xip_read");
        chk("xip_read/first_nibble", strm_at(0, 0), 5'h10);

        txn(0, 24'($urandom), 1'b0, "rand_a");
        txn(0, 24'($urandom), 1'b1, "rd_while_busy");
        repeat (4) @(negedge clk);
        chk("rd_while_busy/stays_idle", {busy_v[0], ce_v[0]}, 2'b01);
        txn(0, 24'($urandom), 1'b0, "rand_b");

        pre = mx[0] ? 0 : 8;
        a = 24'($urandom);
        @(negedge clk); addr_v[0] = a; rd_v[0] = 1'b1;
        @(negedge clk); rd_v[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            if (rises_v[0] > pre + 8 + DM0 + 5) got = 1'b1;
            else @(negedge clk);
        end
        chk("midreset/reached_data", got, 1);
        rst_v[0] = 1'b0;
        #1;
        chk("midreset/ce_n", ce_v[0], 1);
        chk("midreset/sck", sck_v[0], 0);
        chk("midreset/busy_done", {busy_v[0], done_v[0]}, 2'b00);
        chk("midreset/line", line_v[0], 0);
        chk("midreset/douten_dout", {douten_v[0], dout_v[0]}, 5'h10);
        @(negedge clk); rst_v[0] = 1'b1; mx[0] = 1'b0;
        txn(0, 24'($urandom), 1'b0, "after_reset");

        txn(1, 24'($urandom), 1'b0, "b_first");
        txn(1, 24'($urandom), 1'b0, "b_second");

        repeat (3) @(negedge clk);
        chk("a/ce_gap_ge2", gap_v[0] >= 2, 1);
        chk("b/ce_gap_ge2", gap_v[1] >= 2, 1);
        chk("a/pad_rules", 256'(viol_v[0]), 0);
        chk("b/pad_rules", 256'(viol_v[1]), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion expected finish before %0d ns", 5_000_000);
        $fatal(1, "watchdog expired");
    end

endmodule
